// File: rtl/instr_encoder.sv
// Program loader: validates field-level instruction requests, packs them into
// 32-bit words and writes them sequentially to program memory with a held-write handshake.
module instr_encoder #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_opcode,
    input  logic [4:0]            in_rc,
    input  logic [4:0]            in_ra,
    input  logic [4:0]            in_rb,
    input  logic [15:0]           in_lit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [2:0]            dbg_state
);

    // Handshakes: a bundle transfers on a rising edge where in_valid && in_ready;
    // a write completes on a rising edge where mem_we && mem_ack. mem_we, mem_addr
    // and mem_wdata hold steady until that edge.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_is_exit;

    logic                  w_is_exit;
    logic                  w_legal;
    logic [31:0]           w_word;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Legal space: EXIT, 011xxx, and 1xxxxx except the xxx=111 slot of each group.
    always_comb begin
        w_is_exit = (in_opcode == 6'b000000);
        w_legal   = w_is_exit
                  || (in_opcode[5:3] == 3'b011)
                  || (in_opcode[5] && (in_opcode[2:0] != 3'b111));
        if (w_is_exit) begin
            w_word = 32'h0;
        end else if (in_opcode[5:4] == 2'b10) begin
            w_word = {in_opcode, in_rc, in_ra, in_rb, 11'b0};
        end else begin
            w_word = {in_opcode, in_rc, in_ra, in_lit};
        end
    end

    assign w_count_next = r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_count    <= '0;
            r_is_exit  <= 1'b0;
        end else if (start) begin
            // Restart from any state; a pending write or a coincident bundle is dropped.
            r_state    <= S_ACCEPT;
            r_in_ready <= 1'b1;
            r_mem_we   <= 1'b0;
            r_addr     <= BASE;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_count    <= '0;
            r_is_exit  <= 1'b0;
        end else begin
            case (r_state)
                S_ACCEPT: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (!w_legal) begin
                            r_state    <= S_ERROR;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= 2'd1;
                        end else begin
                            r_state   <= S_WRITE;
                            r_mem_we  <= 1'b1;
                            r_wdata   <= w_word;
                            r_is_exit <= w_is_exit;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_mem_we <= 1'b0;
                        r_count  <= w_count_next;
                        r_addr   <= r_addr + 1'b1;
                        if (r_is_exit) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_count_next == CAPACITY) begin
                            r_state    <= S_ERROR;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                        end else begin
                            r_state    <= S_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign word_count = r_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized runs, with an
// expected-write queue drained by an independent memory-side monitor.
module tb_instr_encoder;

    localparam int AW   = 2;
    localparam int BASE = 0;
    localparam int CAP  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    in_opcode = '0;
    logic [4:0]    in_rc = '0, in_ra = '0, in_rb = '0;
    logic [15:0]   in_lit = '0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic          mem_ack = 1'b0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW:0]   word_count;
    logic [2:0]    dbg_state;

    instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rc(in_rc), .in_ra(in_ra), .in_rb(in_rb), .in_lit(in_lit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .word_count(word_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [AW+31:0] exp_q[$];

    // Reference model of the run: words written so far and how the run stands.
    // status: 0 running, 1 done on EXIT, 2 illegal opcode, 3 overflow
    int m_count  = 0;
    int m_status = 0;
    int ack_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic bit ref_legal(input int op);
        return (op == 0) || (op >= 24 && op <= 31) || (op >= 32 && (op % 8) != 7);
    endfunction

    function automatic logic [31:0] ref_pack(input int op, input int rc, input int ra,
                                             input int rb, input int lit);
        int unsigned w;
        if (op == 0) return 32'h0;
        w = (op << 26) + (rc << 21) + (ra << 16);
        if (op >= 32 && op < 48) w = w + (rb << 11);
        else w = w + lit;
        return w;
    endfunction

    // Memory side: random ack latency unless a test takes manual control.
    always begin
        @(posedge clk);
        #2;
        if (ack_mode == 0) mem_ack = mem_we && ($urandom_range(0, 3) != 0);
    end

    // Monitor: held-write stability, in_ready exclusion, and write contents.
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_data;
    logic [AW+31:0] mon_e;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("we_held", mem_we, 1);
                chk("addr_stable", mem_addr, prev_addr);
                chk("data_stable", mem_wdata, prev_data);
            end
            if (mem_we) begin
                chk("in_ready_low_in_write", in_ready, 0);
                if (mem_ack && !start) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: addr %0h data %0h at %0t", mem_addr, mem_wdata, $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("write_addr", mem_addr, mon_e[AW+31:32]);
                        chk("write_data", mem_wdata, mon_e[31:0]);
                    end
                end
            end
            prev_hold = mem_we && !mem_ack && !start;
            prev_addr = mem_addr;
            prev_data = mem_wdata;
        end
    end

    task automatic check_status(input string name);
        logic rdy, bsy, dn, er;
        logic [1:0] code;
        rdy = (m_status == 0);
        bsy = (m_status == 0);
        dn  = (m_status == 1);
        er  = (m_status >= 2);
        code = (m_status == 2) ? 2'd1 : (m_status == 3) ? 2'd2 : 2'd0;
        chk({name, "_in_ready"}, in_ready, rdy);
        chk({name, "_busy"}, busy, bsy);
        chk({name, "_done"}, done, dn);
        chk({name, "_err"}, err, er);
        chk({name, "_err_code"}, err_code, code);
        chk({name, "_word_count"}, word_count, m_count);
        chk({name, "_mem_we"}, mem_we, 0);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        m_count  = 0;
        m_status = 0;
        check_status("start");
        chk("start_addr", mem_addr, BASE);
    endtask

    // Offer one bundle; returns with the bundle accepted (ok=1), at #1 after the accept edge.
    task automatic issue(input int op, input int rc, input int ra, input int rb,
                         input int lit, output bit ok);
        int waitc;
        waitc = 0;
        ok = 1'b0;
        in_opcode = op[5:0]; in_rc = rc[4:0]; in_ra = ra[4:0]; in_rb = rb[4:0]; in_lit = lit[15:0];
        while (in_ready !== 1'b1) begin
            @(posedge clk); #1;
            waitc++;
            if (waitc > 50) begin
                fail_now("in_ready_wait");
                return;
            end
        end
        in_valid = 1'b1;
        if (ref_legal(op))
            exp_q.push_back({AW'((BASE + m_count) % CAP), ref_pack(op, rc, ra, rb, lit)});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_opcode = $urandom_range(0, 63);
        in_lit = $urandom_range(0, 65535);
        ok = 1'b1;
        if (!ref_legal(op)) begin
            m_status = 2;
            check_status("illegal");
        end else begin
            chk("we_after_accept", mem_we, 1);
        end
    endtask

    task automatic finish_write(input int op);
        int waitc;
        waitc = 0;
        while (mem_we !== 1'b0) begin
            @(posedge clk); #1;
            waitc++;
            if (waitc > 100) begin
                fail_now("write_complete_wait");
                return;
            end
        end
        m_count++;
        if (op == 0) m_status = 1;
        else if (m_count == CAP) m_status = 3;
        check_status("after_write");
    endtask

    task automatic send(input int op, input int rc, input int ra, input int rb, input int lit);
        bit ok;
        issue(op, rc, ra, rb, lit, ok);
        if (ok && ref_legal(op)) finish_write(op);
    endtask

    function automatic int rand_opcode();
        int k;
        int op;
        k = $urandom_range(0, 9);
        if (k == 0) return 0;
        if (k == 1) begin
            if ($urandom_range(0, 1) == 0) return $urandom_range(1, 23);
            return 8 * $urandom_range(4, 7) + 7;
        end
        do op = $urandom_range(1, 63); while (!ref_legal(op));
        return op;
    endfunction

    initial begin
        bit ok;
        int we_cycles, rdy_high;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_word_count", word_count, 0);
        reset = 1'b0;

        // ADD, then ADDC and EXIT with nonzero fields
        do_start();
        send(6'b100000, 3, 1, 2, 16'hFFFF);
        chk("add_word", ref_pack(6'b100000, 3, 1, 2, 16'hFFFF), 32'h80611000);
        do_start();
        send(6'b110000, 4, 4, 7, 16'h1234);
        chk("addc_word", ref_pack(6'b110000, 4, 4, 7, 16'h1234), 32'hC0841234);
        send(0, 5, 7, 9, 16'hABCD);

        // Illegal opcode after a legal word; the next start clears err
        do_start();
        send(6'b011010, 1, 2, 3, 16'h0042);
        send(6'b100111, 1, 1, 1, 16'h1111);
        do_start();

        // Delayed ack: held for 4 cycles, in_ready low throughout
        ack_mode = 1;
        mem_ack = 1'b0;
        issue(6'b101001, 9, 10, 11, 16'h5555, ok);
        we_cycles = 0;
        rdy_high = 0;
        repeat (3) begin
            if (mem_we) we_cycles++;
            if (in_ready) rdy_high++;
            @(posedge clk); #1;
        end
        if (mem_we) we_cycles++;
        if (in_ready) rdy_high++;
        #1 mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("delayed_we_cycles", we_cycles, 4);
        chk("delayed_in_ready_low", rdy_high, 0);
        m_count++;
        check_status("delayed_ack");
        ack_mode = 0;

        // Overflow: four non-EXIT words fill the memory
        do_start();
        for (int i = 0; i < CAP; i++)
            send(6'b111000 + (i % 7), i + 1, i + 2, i + 3, 16'h1000 + i);
        in_opcode = 6'b100001;
        in_valid = 1'b1;
        we_cycles = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_we) we_cycles++;
        end
        in_valid = 1'b0;
        chk("overflow_no_fifth_write", we_cycles, 0);
        check_status("overflow_hold");

        // Restart mid-write abandons the pending word
        do_start();
        send(6'b011111, 2, 3, 4, 16'h0BEE);
        ack_mode = 1;
        mem_ack = 1'b0;
        issue(6'b100010, 6, 7, 8, 16'h0, ok);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ack_mode = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        m_count = 0;
        m_status = 0;
        check_status("restart_mid_write");
        chk("restart_addr", mem_addr, BASE);

        // Reset while in ACCEPT
        send(6'b011000, 1, 1, 1, 16'h0001);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst2_in_ready", in_ready, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_word_count", word_count, 0);
        chk("rst2_mem_addr", mem_addr, 0);
        chk("rst2_mem_wdata", mem_wdata, 0);
        chk("rst2_err_done", {err, done, err_code}, 0);
        reset = 1'b0;

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            do_start();
            for (int w = 0; w < 10 && m_status == 0; w++)
                send(rand_opcode(), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 65535));
            chk("run_ended", (m_status != 0), 1);
        end

        repeat (4) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader that turns field-level instruction requests into 32-bit instruction words in the team's instruction format and writes them sequentially into instruction memory. Fields arrive over a valid/ready handshake from the host or test front-end. The block validates each opcode, packs the word in register or literal format, and performs a held-write handshake to the program memory port. A run ends on EXIT, an illegal opcode, or memory overflow. It is the writer counterpart of the CPU fetch/decode path.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width of program memory; capacity is 2^ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins or restarts a load run.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- in_opcode  in  6  opcode.
- in_rc, in_ra, in_rb  in  5 each  register fields.
- in_lit  in  16  literal field.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  packed instruction.
- mem_we  out  1  write request; held until acknowledged.
- mem_ack  in  1  memory accepted the write; sampled only while mem_we=1.
- busy  out  1  run in progress.
- done  out  1  run ended on EXIT.
- err  out  1  run ended on error.
- err_code  out  2  0 none, 1 illegal opcode, 2 overflow.
- word_count  out  ADDR_WIDTH+1  words written this run.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE: all outputs 0. On start, go to ACCEPT, set addr=BASE_ADDR, clear count, err, and done.
- ACCEPT: in_ready=1 and busy=1. On in_valid, latch and classify the bundle.
  - Illegal opcode: go to ERROR with err_code=1. Nothing is written.
  - Legal opcode: pack the word and go to WRITE.
- Legal opcodes:
  - 000000 (EXIT)
  - 011000–011111
  - 100000–100110
  - 101000–101110
  - 110000–110110
  - 111000–111110
  - Every other value, including 100111, 101111, 110111 and 111111, is illegal.
- Packing:
  - Register format, for opcode[5:4]=2'b10: {opcode, rc, ra, rb, 11'b0}. in_lit is ignored.
  - Literal format, for every other legal opcode except EXIT: {opcode, rc, ra, lit}. in_rb is ignored.
  - EXIT: always packs to 32'h0, regardless of the register and literal fields.
- WRITE: mem_we=1. mem_addr and mem_wdata stay stable until mem_ack. On the ack cycle, count is incremented and addr is incremented, wrapping modulo 2^ADDR_WIDTH. Next state on that edge:
  - If the word was EXIT: DONE.
  - Else if count has reached 2^ADDR_WIDTH: ERROR with err_code=2.
  - Else: ACCEPT.
- DONE: done=1, busy=0. Holds until start or reset.
- ERROR: err=1, busy=0, and err_code holds its value. Holds until start or reset.
- start in any non-IDLE state restarts the run identically to start from IDLE.
  - If start coincides with in_valid in ACCEPT, start wins and the bundle is not accepted.
  - If start arrives in WRITE, the pending write is abandoned: mem_we drops the next cycle.
- reset in any state returns to IDLE with every output 0 the next cycle, including mid-write.
- word_count is held through DONE and ERROR.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_code=0, word_count=0.
- start pulse at edge N: in_ready=1 and busy=1 from cycle N+1.
- Bundle accepted at edge N: in_ready=0 and mem_we=1 with valid addr and data from cycle N+1.
- mem_ack seen at edge M: mem_we=0 from M+1. in_ready=1 from M+1, unless the run is ending.
- Peak throughput is one word per 2 cycles, with mem_ack returned in the first write cycle.
- Illegal opcode accepted at edge N: err=1 and err_code=1 from cycle N+1. mem_we never asserts.
- done, err and err_code are registered outputs. They change only on the state transitions above.

## Test plan
- ADD: start, then opcode 100000, rc=3, ra=1, rb=2, lit=16'hFFFF. Required: one write, addr 0, wdata 32'h80611000, word_count=1, in_ready returns to 1.
- ADDC then EXIT: opcode 110000, rc=4, ra=4, lit=16'h1234, then EXIT with nonzero fields. Required: addr 0 gets 32'hC0841234, addr 1 gets 32'h00000000, done=1, word_count=2.
- Illegal opcode: opcode 100111 after one legal word. Required: err=1, err_code=1, no mem_we pulse, word_count=1. A following start clears err.
- Delayed ack: hold mem_ack low for 3 cycles during a write. Required: mem_we, mem_addr and mem_wdata stable for 4 cycles; in_ready=0 throughout; exactly one count increment.
- Overflow: ADDR_WIDTH=2, write four non-EXIT words. Required: writes to addrs 0–3, then err_code=2, word_count=4, and no fifth write.
- Restart and reset: start asserted mid-WRITE. Required: mem_we drops, addr returns to BASE_ADDR. Separately, reset in ACCEPT. Required: all outputs 0 the next cycle.
